// File: rtl/rv32i_pkg.sv
// Shared rv32i constants and encodings for the integer pipeline.
package rv32i_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned REG_COUNT      = 32;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_e;

endpackage

// File: rtl/writeback_stage_if.sv
// Writeback-stage bus: ALU/load producers, issue scoreboard taps, register-file write port.
interface writeback_stage_if;
  import rv32i_pkg::*;

  logic                      alu_valid;
  logic                      alu_ready;
  logic [REG_ADDR_WIDTH-1:0] alu_rd;
  logic [XLEN-1:0]           alu_result;

  logic                      ld_valid;
  logic                      ld_ready;
  logic [REG_ADDR_WIDTH-1:0] ld_rd;
  logic [XLEN-1:0]           ld_word;
  logic [2:0]                ld_funct3;
  logic [1:0]                ld_byte_off;

  logic                      iss_valid;
  logic [REG_ADDR_WIDTH-1:0] iss_rd;
  logic [REG_ADDR_WIDTH-1:0] chk_addr1;
  logic [REG_ADDR_WIDTH-1:0] chk_addr2;
  logic                      busy1;
  logic                      busy2;

  logic                      wr_en;
  logic [REG_ADDR_WIDTH-1:0] wr_addr;
  logic [XLEN-1:0]           wdata;
  logic                      ld_err;

  // Pipeline side: producers, issue logic and register file.
  modport master (
    output alu_valid, alu_rd, alu_result,
    output ld_valid, ld_rd, ld_word, ld_funct3, ld_byte_off,
    output iss_valid, iss_rd, chk_addr1, chk_addr2,
    input  alu_ready, ld_ready, busy1, busy2,
    input  wr_en, wr_addr, wdata, ld_err
  );

  // Writeback stage itself.
  modport slave (
    input  alu_valid, alu_rd, alu_result,
    input  ld_valid, ld_rd, ld_word, ld_funct3, ld_byte_off,
    input  iss_valid, iss_rd, chk_addr1, chk_addr2,
    output alu_ready, ld_ready, busy1, busy2,
    output wr_en, wr_addr, wdata, ld_err
  );

endinterface

// File: rtl/writeback_stage_load_align.sv
// Load data alignment and sign/zero extension with misalignment/illegal-type detection.
module load_align
  import rv32i_pkg::*;
(
  input  logic [XLEN-1:0] ld_word,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_byte_off,
  output logic [XLEN-1:0] data,
  output logic            err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = ld_word[{ld_byte_off, 3'b000} +: 8];
  assign half_sel = ld_word[{ld_byte_off[1], 4'b0000} +: 16];

  // Select lane and extend; unknown funct3 values are flagged as errors.
  always_comb begin
    data = '0;
    err  = 1'b0;
    case (ld_funct3)
      LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
      LH: begin
        data = {{(XLEN-16){half_sel[15]}}, half_sel};
        err  = ld_byte_off[0];
      end
      LHU: begin
        data = {{(XLEN-16){1'b0}}, half_sel};
        err  = ld_byte_off[0];
      end
      LW: begin
        data = ld_word;
        err  = (ld_byte_off != 2'b00);
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: load/ALU arbitration, registered GPR write port, RAW scoreboard.
module writeback_stage
  import rv32i_pkg::*;
(
  input  logic               clk,
  input  logic               areset,
  writeback_stage_if.slave   bus
);

  logic [XLEN-1:0]           ld_data;
  logic                      ld_bad;
  logic                      ld_fire;
  logic                      alu_fire;

  logic                      wr_en_q, wr_en_d;
  logic [REG_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]           wdata_q, wdata_d;
  logic                      ld_err_q, ld_err_d;
  logic [REG_COUNT-1:0]      pending_q, pending_d;

  load_align u_load_align (
    .ld_word     (bus.ld_word),
    .ld_funct3   (bus.ld_funct3),
    .ld_byte_off (bus.ld_byte_off),
    .data        (ld_data),
    .err         (ld_bad)
  );

  // Loads always win; the ALU is back-pressured whenever a load is offered.
  assign bus.ld_ready  = ~areset;
  assign bus.alu_ready = ~bus.ld_valid;
  assign ld_fire       = bus.ld_valid & bus.ld_ready;
  assign alu_fire      = bus.alu_valid & bus.alu_ready;

  // Next write-port value and scoreboard update; an issue on the retiring register wins.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wdata_d   = wdata_q;
    ld_err_d  = 1'b0;
    pending_d = pending_q;
    if (ld_fire) begin
      wr_en_d              = (bus.ld_rd != '0) & ~ld_bad;
      wr_addr_d            = bus.ld_rd;
      wdata_d              = ld_data;
      ld_err_d             = ld_bad;
      pending_d[bus.ld_rd] = 1'b0;
    end else if (alu_fire) begin
      wr_en_d               = (bus.alu_rd != '0);
      wr_addr_d             = bus.alu_rd;
      wdata_d               = bus.alu_result;
      pending_d[bus.alu_rd] = 1'b0;
    end
    if (bus.iss_valid && (bus.iss_rd != '0)) begin
      pending_d[bus.iss_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // State registers; reset drops any in-flight result.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wdata_q   <= '0;
      ld_err_q  <= 1'b0;
      pending_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wdata_q   <= wdata_d;
      ld_err_q  <= ld_err_d;
      pending_q <= pending_d;
    end
  end

  // Busy also covers the cycle the write is on the port, so readers never see stale data.
  assign bus.busy1 = (bus.chk_addr1 != '0) &
                     (pending_q[bus.chk_addr1] | (wr_en_q & (wr_addr_q == bus.chk_addr1)));
  assign bus.busy2 = (bus.chk_addr2 != '0) &
                     (pending_q[bus.chk_addr2] | (wr_en_q & (wr_addr_q == bus.chk_addr2)));

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wdata   = wdata_q;
  assign bus.ld_err  = ld_err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus randomized traffic vs a model.
module tb_writeback_stage;
  import rv32i_pkg::*;

  logic clk;
  logic areset;
  int   n_tests;
  int   n_fail;

  writeback_stage_if bus ();

  writeback_stage dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: what the register file should see next, and who is pending.
  logic        m_wr_en;
  logic [4:0]  m_wr_addr;
  logic [31:0] m_wdata;
  logic        m_ld_err;
  logic [31:0] m_pending;

  // Load result from the architectural rules using plain shifts and arithmetic.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f,
                                           input logic [1:0] off, output logic e);
    logic [31:0] sh;
    logic [31:0] v;
    sh = w >> (8 * off);
    e  = 1'b0;
    v  = 32'd0;
    case (f)
      3'd0, 3'd4: begin
        v = sh & 32'hFF;
        if (f == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        v = sh & 32'hFFFF;
        if (f == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
        e = (off % 2) != 0;
      end
      3'd2: begin
        v = w;
        e = off != 0;
      end
      default: e = 1'b1;
    endcase
    return v;
  endfunction

  function automatic logic m_busy(input logic [4:0] a);
    return (a != 0) && (m_pending[a] || (m_wr_en && m_wr_addr == a));
  endfunction

  // Model update at each edge from the inputs the DUT sees.
  always @(posedge clk or posedge areset) begin
    logic        e;
    logic [31:0] v;
    if (areset) begin
      m_wr_en   <= 1'b0;
      m_wr_addr <= 5'd0;
      m_wdata   <= 32'd0;
      m_ld_err  <= 1'b0;
      m_pending <= 32'd0;
    end else begin
      m_wr_en  <= 1'b0;
      m_ld_err <= 1'b0;
      if (bus.ld_valid) begin
        v = ref_load(bus.ld_word, bus.ld_funct3, bus.ld_byte_off, e);
        m_wr_en              <= (bus.ld_rd != 0) && !e;
        m_wr_addr            <= bus.ld_rd;
        m_wdata              <= v;
        m_ld_err             <= e;
        m_pending[bus.ld_rd] <= 1'b0;
      end else if (bus.alu_valid) begin
        m_wr_en               <= bus.alu_rd != 0;
        m_wr_addr             <= bus.alu_rd;
        m_wdata               <= bus.alu_result;
        m_pending[bus.alu_rd] <= 1'b0;
      end
      if (bus.iss_valid && bus.iss_rd != 0) m_pending[bus.iss_rd] <= 1'b1;
    end
  end

  task automatic idle_inputs();
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = 5'd0;
    bus.alu_result  = 32'd0;
    bus.ld_valid    = 1'b0;
    bus.ld_rd       = 5'd0;
    bus.ld_word     = 32'd0;
    bus.ld_funct3   = 3'd0;
    bus.ld_byte_off = 2'd0;
    bus.iss_valid   = 1'b0;
    bus.iss_rd      = 5'd0;
    bus.chk_addr1   = 5'd0;
    bus.chk_addr2   = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    areset = 1'b1;
    #12;
    n_tests++;
    if (bus.wr_en !== 1'b0 || bus.wr_addr !== 5'd0 || bus.wdata !== 32'd0 ||
        bus.ld_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b addr=%0d data=%h err=%b, want all zero",
               bus.wr_en, bus.wr_addr, bus.wdata, bus.ld_err);
    end
    areset = 1'b0;
    #2;
    n_tests++;
    if (bus.ld_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got ld_ready=%b alu_ready=%b, want 1 1",
               bus.ld_ready, bus.alu_ready);
    end
    tick();
  endtask

  task automatic test_alu_write();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_result = 32'hDEAD_BEEF;
    tick();
    bus.alu_valid = 1'b0;
    n_tests++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd5 || bus.wdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL alu_write: got en=%b addr=%0d data=%h, want 1 5 deadbeef",
               bus.wr_en, bus.wr_addr, bus.wdata);
    end
    tick();
    n_tests++;
    if (bus.wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_write_drop: got en=%b, want 0", bus.wr_en);
    end
  endtask

  task automatic test_arbitration();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd11; bus.alu_result = 32'h1234_5678;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd12; bus.ld_word = 32'hCAFE_F00D;
    bus.ld_funct3 = 3'd2; bus.ld_byte_off = 2'd0;
    #1;
    n_tests++;
    if (bus.alu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL arb_alu_ready: got %b, want 0", bus.alu_ready);
    end
    tick();
    bus.ld_valid = 1'b0;
    n_tests++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd12 || bus.wdata !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL arb_load_first: got en=%b addr=%0d data=%h, want 1 12 cafef00d",
               bus.wr_en, bus.wr_addr, bus.wdata);
    end
    tick();
    bus.alu_valid = 1'b0;
    n_tests++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd11 || bus.wdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL arb_alu_second: got en=%b addr=%0d data=%h, want 1 11 12345678",
               bus.wr_en, bus.wr_addr, bus.wdata);
    end
    tick();
  endtask

  task automatic test_load_align();
    logic [2:0]  f3   [4] = '{3'd0, 3'd0, 3'd5, 3'd1};
    logic [1:0]  off  [4] = '{2'd1, 2'd3, 2'd2, 2'd1};
    logic [31:0] want [4] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_80FF, 32'h0};
    logic        werr [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b1; bus.ld_rd = 5'd20; bus.ld_word = 32'h80FF_7F01;
      bus.ld_funct3 = f3[i]; bus.ld_byte_off = off[i];
      tick();
      bus.ld_valid = 1'b0;
      n_tests++;
      if (bus.ld_err !== werr[i] || bus.wr_en !== !werr[i] ||
          (!werr[i] && bus.wdata !== want[i])) begin
        n_fail++;
        $display("FAIL load_align[%0d]: got en=%b err=%b data=%h, want en=%b err=%b data=%h",
                 i, bus.wr_en, bus.ld_err, bus.wdata, !werr[i], werr[i], want[i]);
      end
    end
    tick();
    n_tests++;
    if (bus.ld_err !== 1'b0) begin
      n_fail++;
      $display("FAIL load_err_pulse: got %b, want 0", bus.ld_err);
    end
  endtask

  task automatic test_scoreboard();
    bus.chk_addr1 = 5'd7;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    tick();
    bus.iss_valid = 1'b0;
    n_tests++;
    if (bus.busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_issue_busy: got %b, want 1", bus.busy1);
    end
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_word = 32'h55;
    bus.ld_funct3 = 3'd2; bus.ld_byte_off = 2'd0;
    tick();
    bus.ld_valid = 1'b0;
    n_tests++;
    if (bus.busy1 !== 1'b1 || bus.wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_inflight_busy: got busy=%b en=%b, want 1 1", bus.busy1, bus.wr_en);
    end
    tick();
    n_tests++;
    if (bus.busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_retired_busy: got %b, want 0", bus.busy1);
    end
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    tick();
    bus.iss_valid = 1'b0;
    bus.ld_valid = 1'b1; bus.iss_valid = 1'b1;
    tick();
    bus.ld_valid = 1'b0; bus.iss_valid = 1'b0;
    tick();
    n_tests++;
    if (bus.busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_set_wins: got %b, want 1", bus.busy1);
    end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7;
    tick();
    bus.alu_valid = 1'b0;
    tick();
    bus.chk_addr1 = 5'd0;
  endtask

  task automatic test_x0();
    bus.chk_addr1 = 5'd0; bus.chk_addr2 = 5'd0;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_result = 32'hFFFF_FFFF;
    tick();
    bus.iss_valid = 1'b0; bus.alu_valid = 1'b0;
    n_tests++;
    if (bus.wr_en !== 1'b0 || bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_alu: got en=%b busy=%b%b, want 0 00", bus.wr_en, bus.busy1, bus.busy2);
    end
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd0; bus.ld_funct3 = 3'd2; bus.ld_byte_off = 2'd0;
    tick();
    bus.ld_valid = 1'b0;
    n_tests++;
    if (bus.wr_en !== 1'b0 || bus.busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_load: got en=%b busy=%b, want 0 0", bus.wr_en, bus.busy1);
    end
  endtask

  task automatic test_async_reset();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
    tick();
    bus.iss_rd = 5'd9;
    tick();
    bus.iss_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_result = 32'hABCD_0123;
    tick();
    bus.chk_addr1 = 5'd3; bus.chk_addr2 = 5'd9;
    #1;
    n_tests++;
    if (bus.wr_en !== 1'b1 || bus.busy1 !== 1'b1 || bus.busy2 !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre: got en=%b busy=%b%b, want 1 11", bus.wr_en, bus.busy1, bus.busy2);
    end
    #1;
    areset = 1'b1;
    #1;
    n_tests++;
    if (bus.wr_en !== 1'b0 || bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_immediate: got en=%b busy=%b%b, want 0 00",
               bus.wr_en, bus.busy1, bus.busy2);
    end
    bus.alu_valid = 1'b0;
    #10;
    areset = 1'b0;
    tick();
    tick();
    n_tests++;
    if (bus.wr_en !== 1'b0 || bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_release: got en=%b busy=%b%b, want 0 00",
               bus.wr_en, bus.busy1, bus.busy2);
    end
    bus.chk_addr1 = 5'd0; bus.chk_addr2 = 5'd0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.alu_valid   = ($urandom_range(0, 99) < 60);
      bus.alu_rd      = 5'($urandom_range(0, 31));
      bus.alu_result  = $urandom;
      bus.ld_valid    = ($urandom_range(0, 99) < 40);
      bus.ld_rd       = 5'($urandom_range(0, 31));
      bus.ld_word     = $urandom;
      bus.ld_funct3   = 3'($urandom_range(0, 7));
      bus.ld_byte_off = 2'($urandom_range(0, 3));
      bus.iss_valid   = ($urandom_range(0, 99) < 50);
      bus.iss_rd      = 5'($urandom_range(0, 31));
      bus.chk_addr1   = 5'($urandom_range(0, 31));
      bus.chk_addr2   = (i % 2 == 0) ? m_wr_addr : 5'($urandom_range(0, 31));
      #1;
      n_tests++;
      if (bus.busy1 !== m_busy(bus.chk_addr1) || bus.busy2 !== m_busy(bus.chk_addr2) ||
          bus.alu_ready !== !bus.ld_valid) begin
        n_fail++;
        $display("FAIL rand_comb[%0d]: got busy=%b%b alu_ready=%b, want %b%b %b", i,
                 bus.busy1, bus.busy2, bus.alu_ready, m_busy(bus.chk_addr1),
                 m_busy(bus.chk_addr2), !bus.ld_valid);
      end
      tick();
      n_tests++;
      if (bus.wr_en !== m_wr_en || bus.ld_err !== m_ld_err ||
          (m_wr_en && (bus.wr_addr !== m_wr_addr || bus.wdata !== m_wdata))) begin
        n_fail++;
        $display("FAIL rand_write[%0d]: got en=%b err=%b addr=%0d data=%h, want %b %b %0d %h",
                 i, bus.wr_en, bus.ld_err, bus.wr_addr, bus.wdata,
                 m_wr_en, m_ld_err, m_wr_addr, m_wdata);
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    areset  = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_alu_write();
    test_arbitration();
    test_load_align();
    test_scoreboard();
    test_x0();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
